// File: rtl/demux_rr_dispatcher.sv
// Round-robin 1:4 dispatcher: one word in, delivered to the next channel in turn.
// Optional DEMUX_RR_SKIP_BUSY_EN retargets a stalled word to the next ready channel.
module demux_rr_dispatcher (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] I,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [3:0] A,
  output logic [3:0] B,
  output logic [3:0] C,
  output logic [3:0] D,
  output logic [3:0] out_valid,
  input  logic [3:0] out_ready,
  output logic [1:0] S,
  output logic [7:0] disp_cnt
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t     state, state_nx;
  logic [3:0] hold, hold_nx;
  logic [1:0] ptr, ptr_nx;
  logic [1:0] s_q, s_nx;
  logic [7:0] cnt, cnt_nx;

`ifdef DEMUX_RR_SKIP_BUSY_EN
  function automatic logic [1:0] next_ready(
    input logic [1:0] s,
    input logic [3:0] r
  );
    logic [1:0] c;
    next_ready = s;
    for (int k = 3; k >= 1; k--) begin
      c = s + 2'(k);
      if (r[c]) next_ready = c;
    end
  endfunction
`endif

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      hold  <= 4'd0;
      ptr   <= 2'd0;
      s_q   <= 2'd0;
      cnt   <= 8'd0;
    end else begin
      state <= state_nx;
      hold  <= hold_nx;
      ptr   <= ptr_nx;
      s_q   <= s_nx;
      cnt   <= cnt_nx;
    end
  end

  // Next-state: capture in IDLE, complete or wait in SEND
  always_comb begin
    state_nx = state;
    hold_nx  = hold;
    ptr_nx   = ptr;
    s_nx     = s_q;
    cnt_nx   = cnt;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          hold_nx  = I;
          s_nx     = ptr;
          state_nx = SEND;
        end
      end
      SEND: begin
        if (out_ready[s_q]) begin
          ptr_nx   = s_q + 2'd1;
          cnt_nx   = cnt + 8'd1;
          state_nx = IDLE;
        end else begin
`ifdef DEMUX_RR_SKIP_BUSY_EN
          if (|out_ready) s_nx = next_ready(s_q, out_ready);
`endif
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Output decode: demux the held word onto the selected channel
  always_comb begin
    in_ready  = (state == IDLE) && !rst;
    out_valid = 4'b0000;
    A = 4'd0;
    B = 4'd0;
    C = 4'd0;
    D = 4'd0;
    if (state == SEND) begin
      out_valid[s_q] = 1'b1;
      unique case (s_q)
        2'd0: A = hold;
        2'd1: B = hold;
        2'd2: C = hold;
        2'd3: D = hold;
        default: ;
      endcase
    end
  end

  assign S        = s_q;
  assign disp_cnt = cnt;

endmodule

// File: tb/tb_demux_rr_dispatcher.sv
// Bench for demux_rr_dispatcher: directed scenarios plus randomized traffic
// checked every cycle against a transaction-level model.
module tb_demux_rr_dispatcher;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] I = 4'd0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] A, B, C, D;
  logic [3:0] out_valid;
  logic [3:0] out_ready = 4'd0;
  logic [1:0] S;
  logic [7:0] disp_cnt;

  int n_chk = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;

  demux_rr_dispatcher dut (
    .clk(clk), .rst(rst), .I(I), .in_valid(in_valid),
    .in_ready(in_ready), .A(A), .B(B), .C(C), .D(D),
    .out_valid(out_valid), .out_ready(out_ready),
    .S(S), .disp_cnt(disp_cnt)
  );

  always #5 clk = ~clk;

  // Transaction model: a word is either pending on a channel or not
  bit m_busy = 1'b0;
  int m_word = 0;
  int m_ch   = 0;
  int m_ptr  = 0;
  int m_cnt  = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_word <= 0;
      m_ch   <= 0;
      m_ptr  <= 0;
      m_cnt  <= 0;
    end else if (!m_busy) begin
      if (in_valid) begin
        m_word <= int'(I);
        m_ch   <= m_ptr;
        m_busy <= 1'b1;
      end
    end else if (out_ready[m_ch]) begin
      m_busy <= 1'b0;
      m_ptr  <= (m_ch + 1) % 4;
      m_cnt  <= (m_cnt + 1) % 256;
    end else begin
`ifdef DEMUX_RR_SKIP_BUSY_EN
      int tgt;
      tgt = -1;
      for (int k = 1; k <= 3; k++)
        if (tgt < 0 && out_ready[(m_ch + k) % 4]) tgt = (m_ch + k) % 4;
      if (tgt >= 0) m_ch <= tgt;
`endif
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      int ev;
      int ed [4];
      ev = m_busy ? (1 << m_ch) : 0;
      for (int c = 0; c < 4; c++)
        ed[c] = (m_busy && m_ch == c) ? m_word : 0;
      chk("cyc_in_ready", int'(in_ready), int'(!m_busy && !rst));
      chk("cyc_out_valid", int'(out_valid), ev);
      chk("cyc_A", int'(A), ed[0]);
      chk("cyc_B", int'(B), ed[1]);
      chk("cyc_C", int'(C), ed[2]);
      chk("cyc_D", int'(D), ed[3]);
      chk("cyc_S", int'(S), m_ch);
      chk("cyc_cnt", int'(disp_cnt), m_cnt);
    end
  end

  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_in_ready", int'(in_ready), 1);
  endtask

  task automatic send(input logic [3:0] w);
    in_valid = 1'b1;
    I = w;
    tick();
    in_valid = 1'b0;
  endtask

  logic [3:0] words [4];

  initial begin
    words[0] = 4'b0100;
    words[1] = 4'b1010;
    words[2] = 4'b0011;
    words[3] = 4'b1110;

    #1;
    chk("reset_valid", int'(out_valid), 0);
    chk("reset_in_ready", int'(in_ready), 0);
    chk("reset_data", int'({D, C, B, A}), 0);
    do_reset();
    chk("post_rst_cnt", int'(disp_cnt), 0);
    chk("post_rst_S", int'(S), 0);
    cmp_en = 1'b1;

    // Fixed-order dispatch
    out_ready = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      send(words[k]);
      chk("fo_S", int'(S), k);
      chk("fo_valid", int'(out_valid), 1 << k);
      chk("fo_data", int'({D, C, B, A} >> (4 * k)) & 15, int'(words[k]));
      tick();
      chk("fo_idle", int'(in_ready), 1);
    end
    chk("fo_cnt", int'(disp_cnt), 4);
    send(4'b0001);
    chk("fo_wrap_S", int'(S), 0);
    chk("fo_wrap_A", int'(A), 1);
    tick();

    // Stall on channel 0
    do_reset();
    out_ready = 4'b0000;
    send(4'b1010);
    for (int k = 0; k < 5; k++) begin
      chk("st_A", int'(A), 10);
      chk("st_valid", int'(out_valid), 1);
      chk("st_in_ready", int'(in_ready), 0);
      tick();
    end
    out_ready = 4'b0001;
    tick();
    chk("st_done_ready", int'(in_ready), 1);
    chk("st_done_valid", int'(out_valid), 0);
    chk("st_cnt", int'(disp_cnt), 1);

    // Retarget from a busy channel
    do_reset();
    out_ready = 4'b1111;
    send(4'b0000);
    tick();
    out_ready = 4'b1000;
    send(4'b0110);
    chk("rt_S0", int'(S), 1);
    chk("rt_valid0", int'(out_valid), 2);
`ifdef DEMUX_RR_SKIP_BUSY_EN
    tick();
    chk("rt_S1", int'(S), 3);
    chk("rt_D", int'(D), 6);
    chk("rt_valid1", int'(out_valid), 8);
    tick();
    chk("rt_done", int'(in_ready), 1);
    chk("rt_cnt", int'(disp_cnt), 2);
    out_ready = 4'b1111;
    send(4'b0101);
    chk("rt_ptr", int'(S), 0);
    tick();
`else
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rr_S", int'(S), 1);
      chk("rr_B", int'(B), 6);
      chk("rr_valid", int'(out_valid), 2);
      chk("rr_cnt", int'(disp_cnt), 1);
    end
    out_ready = 4'b0010;
    tick();
    chk("rr_done", int'(in_ready), 1);
    chk("rr_cnt2", int'(disp_cnt), 2);
    out_ready = 4'b1111;
    send(4'b0101);
    chk("rr_ptr", int'(S), 2);
    tick();
`endif

    // Reset while channel C holds a word
    do_reset();
    out_ready = 4'b1111;
    send(4'b0001);
    tick();
    send(4'b0010);
    tick();
    out_ready = 4'b0000;
    send(4'b1001);
    chk("mr_C", int'(C), 9);
    chk("mr_valid", int'(out_valid), 4);
    rst = 1'b1;
    #1;
    chk("mr_valid0", int'(out_valid), 0);
    chk("mr_data0", int'({D, C, B, A}), 0);
    chk("mr_in_ready", int'(in_ready), 0);
    chk("mr_cnt", int'(disp_cnt), 0);
    tick();
    rst = 1'b0;
    #1;
    chk("mr_ready", int'(in_ready), 1);
    out_ready = 4'b1111;
    tick();
    send(4'b0111);
    chk("mr_next_S", int'(S), 0);
    chk("mr_next_A", int'(A), 7);
    tick();

    // Counter wrap over 256 transfers
    do_reset();
    out_ready = 4'b1111;
    for (int k = 0; k < 256; k++) begin
      send(4'($urandom));
      chk("wr_S", int'(S), k % 4);
      tick();
    end
    chk("wr_cnt", int'(disp_cnt), 0);

    // Randomized traffic with occasional resets
    for (int k = 0; k < 4000; k++) begin
      in_valid = 1'($urandom_range(0, 1));
      I = 4'($urandom);
      out_ready = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom);
      rst = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0;
    in_valid = 1'b0;
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
